// File: rtl/inv_s_box.sv
// AES inverse S-box computed without a table: inverse affine transform, then b^254
// in GF(2^8) by square-and-multiply on a single shared multiplier (13 clock edges).
module inv_s_box (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       done,
    output logic       busy
);

    typedef enum logic {
        IDLE,
        EXP
    } state_t;

    localparam logic [3:0] LAST_STEP = 4'd12;

    state_t     state, state_nxt;
    logic [3:0] step, step_nxt;
    logic [7:0] base, base_nxt;
    logic [7:0] acc, acc_nxt;
    logic [7:0] data_out_nxt;
    logic       done_nxt, busy_nxt;
    logic [7:0] affine, mul_rhs, product;

    // Shift-and-add multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] a;
        p = 8'h00;
        a = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    assign affine = {data_in[6:0], data_in[7]}
                  ^ {data_in[4:0], data_in[7:5]}
                  ^ {data_in[1:0], data_in[7:2]}
                  ^ 8'h05;

    // Even steps square the accumulator, odd steps fold in the base.
    assign mul_rhs = step[0] ? base : acc;
    assign product = gf_mul(acc, mul_rhs);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_nxt    = state;
        step_nxt     = step;
        base_nxt     = base;
        acc_nxt      = acc;
        data_out_nxt = data_out;
        done_nxt     = 1'b0;
        busy_nxt     = busy;

        case (state)
            IDLE: begin
                if (enable) begin
                    base_nxt  = affine;
                    acc_nxt   = affine;
                    step_nxt  = 4'd0;
                    busy_nxt  = 1'b1;
                    state_nxt = EXP;
                end
            end
            EXP: begin
                acc_nxt  = product;
                step_nxt = step + 4'd1;
                if (step == LAST_STEP) begin
                    data_out_nxt = product;
                    done_nxt     = 1'b1;
                    busy_nxt     = 1'b0;
                    step_nxt     = 4'd0;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            step     <= 4'd0;
            base     <= 8'h00;
            acc      <= 8'h00;
            data_out <= 8'h00;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            step     <= step_nxt;
            base     <= base_nxt;
            acc      <= acc_nxt;
            data_out <= data_out_nxt;
            done     <= done_nxt;
            busy     <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_inv_s_box.sv
// Self-checking bench for inv_s_box: directed table, exhaustive round trip against a
// log/antilog S-box model, random traffic, and multi-cycle corner sequences.
module tb_inv_s_box;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       done;
    logic       busy;

    int tests  = 0;
    int failed = 0;

    logic [7:0] sbox_m [256];
    logic [7:0] inv_m  [256];

    typedef struct {
        logic [7:0] din;
        logic [7:0] expect_out;
    } vec_t;

    vec_t vecs [6];

    inv_s_box dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .data_in  (data_in),
        .data_out (data_out),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] w;
        w = {v, v} << n;
        return w[15:8];
    endfunction

    // Forward S-box from generator-3 exp/log tables, then inverted by indexing.
    task automatic build_model();
        logic [7:0] exp_t [256];
        int         log_t [256];
        logic [7:0] p, s;
        p = 8'h01;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = p;
            log_t[p] = i;
            p = p ^ ({p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00));
        end
        for (int x = 0; x < 256; x++) begin
            s = (x == 0) ? 8'h00 : exp_t[(255 - log_t[x]) % 255];
            sbox_m[x] = s ^ rotl8(s, 1) ^ rotl8(s, 2) ^ rotl8(s, 3) ^ rotl8(s, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_m[sbox_m[x]] = 8'(x);
    endtask

    // Returns at the negedge just after the accepting edge.
    task automatic start_op(input logic [7:0] din);
        @(negedge clk);
        enable  = 1'b1;
        data_in = din;
        @(negedge clk);
        enable  = 1'b0;
        data_in = 8'($urandom);
    endtask

    // Counts edges since the accepting edge until done is seen; -1 on timeout.
    task automatic wait_done(output int lat, output int busy_n);
        lat    = -1;
        busy_n = 0;
        for (int e = 0; e <= 40; e++) begin
            if (e > 0) @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                lat = e;
                break;
            end
        end
    endtask

    task automatic do_op(input logic [7:0] din, input logic [7:0] exp_v, input string tag);
        int lat, busy_n;
        start_op(din);
        wait_done(lat, busy_n);
        check($sformatf("%s latency", tag), lat, 13);
        check($sformatf("%s busy cycles", tag), busy_n, 13);
        check($sformatf("%s data_out", tag), data_out, exp_v);
        @(negedge clk);
        check($sformatf("%s done width", tag), done, 1'b0);
    endtask

    initial begin
        int         lat, busy_n, n_done, done_at;
        logic [7:0] din;

        reset   = 1'b1;
        enable  = 1'b0;
        data_in = 8'h00;
        build_model();

        vecs[0] = '{8'h63, 8'h00};
        vecs[1] = '{8'h00, 8'h52};
        vecs[2] = '{8'h7C, 8'h01};
        vecs[3] = '{8'h01, 8'h09};
        vecs[4] = '{8'hED, 8'h53};
        vecs[5] = '{8'h16, 8'hFF};

        @(negedge clk);
        check("reset data_out", data_out, 8'h00);
        check("reset done", done, 1'b0);
        check("reset busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++)
            do_op(vecs[i].din, vecs[i].expect_out, $sformatf("vec%0d(%02h)", i, vecs[i].din));

        for (int x = 0; x < 256; x++)
            do_op(sbox_m[x], 8'(x), $sformatf("sweep %02h", x));

        repeat (40) begin
            din = 8'($urandom);
            do_op(din, inv_m[din], $sformatf("rand %02h", din));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Enable held high with a different byte throughout the busy window.
        @(negedge clk);
        enable  = 1'b1;
        data_in = 8'h7C;
        @(negedge clk);
        data_in = 8'hAA;
        n_done  = 0;
        done_at = -1;
        for (int e = 1; e <= 30; e++) begin
            @(negedge clk);
            if (e == 12) enable = 1'b0;
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = e;
            end
        end
        check("busy-reject done count", n_done, 1);
        check("busy-reject latency", done_at, 13);
        check("busy-reject data_out", data_out, 8'h01);

        // Back-to-back: new start accepted in the done cycle.
        start_op(8'hED);
        wait_done(lat, busy_n);
        check("b2b first latency", lat, 13);
        check("b2b first data_out", data_out, 8'h53);
        enable  = 1'b1;
        data_in = 8'h16;
        @(negedge clk);
        enable  = 1'b0;
        data_in = 8'($urandom);
        check("b2b done drops", done, 1'b0);
        check("b2b second busy", busy, 1'b1);
        wait_done(lat, busy_n);
        check("b2b interval", lat + 1, 14);
        check("b2b second data_out", data_out, 8'hFF);

        // Reset mid-computation at step 6.
        start_op(8'hED);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset async data_out", data_out, 8'h00);
        check("midreset async busy", busy, 1'b0);
        check("midreset async done", done, 1'b0);
        @(negedge clk);
        reset  = 1'b0;
        n_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("midreset no done", n_done, 0);
        check("midreset data_out", data_out, 8'h00);
        do_op(8'h63, 8'h00, "post-reset 63");

        // Hold: idle with toggling data_in.
        do_op(8'h16, 8'hFF, "hold setup");
        for (int i = 0; i < 20; i++) begin
            data_in = (i % 2 == 0) ? 8'hA5 : 8'h5A;
            @(negedge clk);
            check($sformatf("hold data_out c%0d", i), data_out, 8'hFF);
            check($sformatf("hold done c%0d", i), done, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
